// File: rtl/huffman_sched.sv
// Round-robin frame scheduler sharing one huffman core between two pixel sources.
// Clears the core, streams one frame from the granted source, then returns the captured results.
module huffman_sched #(
    parameter int FRAME_LEN  = 100,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  pix_valid,
    input  logic [7:0]  pix_data0,
    input  logic [7:0]  pix_data1,
    output logic [1:0]  pix_ready,
    output logic        core_reset,
    output logic        gray_valid,
    output logic [7:0]  gray_data,
    input  logic        CNT_valid,
    input  logic        code_valid,
    input  logic [47:0] core_cnt,
    input  logic [47:0] core_hc,
    input  logic [47:0] core_m,
    output logic        done,
    output logic        done_id,
    output logic        err_timeout,
    output logic [47:0] res_cnt,
    output logic [47:0] res_hc,
    output logic [47:0] res_m
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        g_q, g_d;
    logic        rr_q, rr_d;
    logic [7:0]  clr_cnt_q, clr_cnt_d;
    logic [7:0]  xfer_cnt_q, xfer_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        cnt_seen_q, cnt_seen_d;
    logic        done_q, done_d;
    logic        done_id_q, done_id_d;
    logic        err_q, err_d;
    logic [47:0] res_cnt_q, res_cnt_d;
    logic [47:0] res_hc_q, res_hc_d;
    logic [47:0] res_m_q, res_m_d;
    logic        sel_s;
    logic        load_rdy_s;
    logic        xfer_s;

    // Datapath toward the core: pass-through of the granted source while loading.
    always_comb begin
        sel_s      = (req == 2'b11) ? rr_q : req[1];
        load_rdy_s = (state_q == S_LOAD) && (xfer_cnt_q < 8'(FRAME_LEN));
        xfer_s     = load_rdy_s && pix_valid[g_q];
        core_reset = !((state_q == S_LOAD) || (state_q == S_WAIT));
        if (state_q == S_LOAD) begin
            gray_valid = pix_valid[g_q];
            gray_data  = g_q ? pix_data1 : pix_data0;
        end else begin
            gray_valid = 1'b0;
            gray_data  = 8'h00;
        end
        if (load_rdy_s) begin
            pix_ready = g_q ? 2'b10 : 2'b01;
        end else begin
            pix_ready = 2'b00;
        end
    end

    // Job sequencing and result capture.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        g_d        = g_q;
        rr_d       = rr_q;
        clr_cnt_d  = clr_cnt_q;
        xfer_cnt_d = xfer_cnt_q;
        wait_cnt_d = wait_cnt_q;
        cnt_seen_d = cnt_seen_q;
        res_cnt_d  = res_cnt_q;
        res_hc_d   = res_hc_q;
        res_m_d    = res_m_q;
        done_id_d  = done_id_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    g_d        = sel_s;
                    gnt_d      = sel_s ? 2'b10 : 2'b01;
                    rr_d       = ~sel_s;
                    clr_cnt_d  = 8'd0;
                    xfer_cnt_d = 8'd0;
                    wait_cnt_d = 8'd0;
                    cnt_seen_d = 1'b0;
                    state_d    = S_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                if (clr_cnt_q == 8'(CLR_CYCLES - 1)) begin
                    state_d = S_LOAD;
                end else begin
                    clr_cnt_d = clr_cnt_q + 8'd1;
                end
            end
            S_LOAD: begin
                if (xfer_s) begin
                    xfer_cnt_d = xfer_cnt_q + 8'd1;
                    if (xfer_cnt_q == 8'(FRAME_LEN - 1)) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WAIT: begin
                if (CNT_valid && !cnt_seen_q) begin
                    res_cnt_d  = core_cnt;
                    cnt_seen_d = 1'b1;
                end else begin
                    cnt_seen_d = cnt_seen_q;
                end
                // A late code_valid still wins over the terminal timeout count.
                if (code_valid) begin
                    res_hc_d  = core_hc;
                    res_m_d   = core_m;
                    done_d    = 1'b1;
                    done_id_d = g_q;
                    state_d   = S_DONE;
                end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    done_id_d = g_q;
                    state_d   = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            gnt_q      <= 2'b00;
            g_q        <= 1'b0;
            rr_q       <= 1'b0;
            clr_cnt_q  <= 8'd0;
            xfer_cnt_q <= 8'd0;
            wait_cnt_q <= 8'd0;
            cnt_seen_q <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= 1'b0;
            err_q      <= 1'b0;
            res_cnt_q  <= 48'd0;
            res_hc_q   <= 48'd0;
            res_m_q    <= 48'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            g_q        <= g_d;
            rr_q       <= rr_d;
            clr_cnt_q  <= clr_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            cnt_seen_q <= cnt_seen_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            err_q      <= err_d;
            res_cnt_q  <= res_cnt_d;
            res_hc_q   <= res_hc_d;
            res_m_q    <= res_m_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign err_timeout = err_q;
    assign res_cnt     = res_cnt_q;
    assign res_hc      = res_hc_q;
    assign res_m       = res_m_q;

endmodule

// File: tb/tb_huffman_sched.sv
// Directed bench for huffman_sched: table of whole jobs plus hand-written
// sequences for contention, mid-frame reset and core-clear timing.
module tb_huffman_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  pix_valid;
    logic [7:0]  pix_data0, pix_data1;
    logic [1:0]  pix_ready;
    logic        core_reset, gray_valid;
    logic [7:0]  gray_data;
    logic        CNT_valid, code_valid;
    logic [47:0] core_cnt, core_hc, core_m;
    logic        done, done_id, err_timeout;
    logic [47:0] res_cnt, res_hc, res_m;

    always #5 clk = ~clk;

    huffman_sched #(.FRAME_LEN(100), .CLR_CYCLES(2), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .pix_valid(pix_valid), .pix_data0(pix_data0), .pix_data1(pix_data1),
        .pix_ready(pix_ready), .core_reset(core_reset),
        .gray_valid(gray_valid), .gray_data(gray_data),
        .CNT_valid(CNT_valid), .code_valid(code_valid),
        .core_cnt(core_cnt), .core_hc(core_hc), .core_m(core_m),
        .done(done), .done_id(done_id), .err_timeout(err_timeout),
        .res_cnt(res_cnt), .res_hc(res_hc), .res_m(res_m)
    );

    int tests = 0;
    int fails = 0;

    // Frame content: 1x40, 2x30, 3x15, 4x8, 5x5, 6x2.
    function automatic logic [7:0] pix_val(input int p);
        if (p < 40)      return 8'd1;
        else if (p < 70) return 8'd2;
        else if (p < 85) return 8'd3;
        else if (p < 93) return 8'd4;
        else if (p < 98) return 8'd5;
        else             return 8'd6;
    endfunction

    // Pixel sources: always offering data, restart from pixel 0 while not granted.
    logic [1:0] stall = 2'b00;
    int cyc = 0;
    int src_idx0 = 0;
    int src_idx1 = 0;
    assign pix_valid[0] = !(stall[0] && (cyc % 3 == 0));
    assign pix_valid[1] = !(stall[1] && (cyc % 3 == 0));
    assign pix_data0 = pix_val(src_idx0);
    assign pix_data1 = pix_val(src_idx1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!gnt[0]) src_idx0 <= 0;
        else if (pix_valid[0] && pix_ready[0]) src_idx0 <= src_idx0 + 1;
        if (!gnt[1]) src_idx1 <= 0;
        else if (pix_valid[1] && pix_ready[1]) src_idx1 <= src_idx1 + 1;
    end

    // Core stub: histogram of accepted symbols, CNT_valid after beat 100, code_valid 20 cycles later.
    logic        code_en = 1'b1;
    logic [47:0] stub_hc = 48'd0;
    logic [7:0]  hist [0:7];
    int          sb = 0;
    int          sc = 0;
    logic        cnt_v = 1'b0;
    logic        code_v = 1'b0;
    assign CNT_valid  = cnt_v;
    assign code_valid = code_v;
    assign core_cnt   = {hist[1], hist[2], hist[3], hist[4], hist[5], hist[6]};
    assign core_hc    = stub_hc;
    assign core_m     = ~stub_hc;

    always @(posedge clk) begin
        if (core_reset) begin
            for (int i = 0; i < 8; i++) hist[i] <= 8'd0;
            sb     <= 0;
            sc     <= 0;
            cnt_v  <= 1'b0;
            code_v <= 1'b0;
        end else begin
            if (gray_valid) begin
                if (gray_data < 8'd8) hist[gray_data[2:0]] <= hist[gray_data[2:0]] + 8'd1;
                sb <= sb + 1;
            end
            cnt_v <= gray_valid && (sb == 99);
            if (cnt_v) sc <= 1;
            else if (sc != 0) sc <= sc + 1;
            code_v <= code_en && (sc == 19);
        end
    end

    // Monitor: beats per job, cycles after the last beat, done pulses, ready after frame end.
    int   gv_beats = 0;
    int   wait_cyc = 0;
    int   done_total = 0;
    logic ready_bad = 1'b0;
    always @(posedge clk) begin
        if (core_reset) begin
            gv_beats <= 0;
            wait_cyc <= 0;
        end else begin
            if (gray_valid) gv_beats <= gv_beats + 1;
            if (gv_beats == 100) wait_cyc <= wait_cyc + 1;
        end
        if (done) done_total <= done_total + 1;
        if (gv_beats >= 100 && pix_ready != 2'b00) ready_bad <= 1'b1;
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(output logic ok);
        int n = 0;
        while (gnt == 2'b00 && n < 10) begin
            @(negedge clk);
            n++;
        end
        ok = (gnt != 2'b00);
        check("grant_within_bound", 48'(ok), 48'd1);
    endtask

    task automatic wait_done(output logic ok);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = done;
        check("done_within_bound", 48'(ok), 48'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 48'(gnt), 48'd0);
        check({tag, "_pix_ready"}, 48'(pix_ready), 48'd0);
        check({tag, "_gray_valid"}, 48'(gray_valid), 48'd0);
        check({tag, "_gray_data"}, 48'(gray_data), 48'd0);
        check({tag, "_core_reset"}, 48'(core_reset), 48'd1);
        check({tag, "_done"}, 48'(done), 48'd0);
        check({tag, "_done_id"}, 48'(done_id), 48'd0);
        check({tag, "_err_timeout"}, 48'(err_timeout), 48'd0);
        check({tag, "_res_cnt"}, res_cnt, 48'd0);
        check({tag, "_res_hc"}, res_hc, 48'd0);
        check({tag, "_res_m"}, res_m, 48'd0);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  stall;
        logic        code_en;
        logic [47:0] stub_hc;
        logic        exp_id;
        logic        exp_err;
        int          exp_wait;
        logic [47:0] exp_cnt;
        logic [47:0] exp_hc;
        logic [47:0] exp_m;
    } vec_t;

    vec_t vecs [4];

    task automatic run_job(input vec_t v, input string tag);
        logic ok;
        stall   = v.stall;
        code_en = v.code_en;
        stub_hc = v.stub_hc;
        req     = v.req;
        wait_gnt(ok);
        check({tag, "_gnt"}, 48'(gnt), 48'(v.req));
        req = 2'b00;
        wait_done(ok);
        if (ok) begin
            check({tag, "_done_id"}, 48'(done_id), 48'(v.exp_id));
            check({tag, "_err_timeout"}, 48'(err_timeout), 48'(v.exp_err));
            check({tag, "_wait_cycles"}, 48'(wait_cyc), 48'(v.exp_wait));
            check({tag, "_beats"}, 48'(gv_beats), 48'd100);
            check({tag, "_res_cnt"}, res_cnt, v.exp_cnt);
            check({tag, "_res_hc"}, res_hc, v.exp_hc);
            check({tag, "_res_m"}, res_m, v.exp_m);
            check({tag, "_ready_after_frame"}, 48'(ready_bad), 48'd0);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 48'(done), 48'd0);
            check({tag, "_gnt_cleared"}, 48'(gnt), 48'd0);
            check({tag, "_core_reset_idle"}, 48'(core_reset), 48'd1);
        end
        stall = 2'b00;
    endtask

    task automatic do_reset();
        req = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    localparam logic [47:0] CNT_EXP = 48'h281E0F080502;
    localparam logic [47:0] HC_A    = 48'h000102030405;
    localparam logic [47:0] M_A     = 48'hFFFEFDFCFBFA;
    localparam logic [47:0] HC_B    = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] M_B     = 48'hF5F4F3F2F1F0;

    initial begin
        logic ok;
        int   n;
        int   snap;

        vecs[0] = '{2'b01, 2'b00, 1'b1, HC_A,            1'b0, 1'b0, 21,  CNT_EXP, HC_A, M_A};
        vecs[1] = '{2'b10, 2'b10, 1'b1, HC_B,            1'b1, 1'b0, 21,  CNT_EXP, HC_B, M_B};
        vecs[2] = '{2'b01, 2'b00, 1'b0, 48'hDEADBEEF0000, 1'b0, 1'b1, 255, CNT_EXP, HC_B, M_B};
        vecs[3] = '{2'b10, 2'b00, 1'b1, HC_A,            1'b1, 1'b0, 21,  CNT_EXP, HC_A, M_A};

        reset = 1'b0;
        req   = 2'b00;
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_job(vecs[i], $sformatf("job%0d", i));
        end

        // Mid-frame reset: everything returns to reset values, aborted frame never reports.
        req = 2'b01;
        wait_gnt(ok);
        req = 2'b00;
        n = 0;
        while (gv_beats < 50 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midreset_reached_50", 48'(gv_beats >= 50), 48'd1);
        snap  = done_total;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_no_done", 48'(done_total), 48'(snap));
        run_job(vecs[0], "after_reset");

        // Core-clear window between grant and first pix_ready.
        code_en = 1'b1;
        stub_hc = HC_A;
        check("clr_idle_core_reset", 48'(core_reset), 48'd1);
        req = 2'b01;
        wait_gnt(ok);
        check("clr_gnt", 48'(gnt), 48'd1);
        n = 0;
        while (pix_ready == 2'b00 && n < 10) begin
            if (core_reset) n++;
            @(negedge clk);
        end
        check("clr_cycles", 48'(n), 48'd2);
        check("clr_first_ready", 48'(pix_ready), 48'd1);
        check("clr_load_core_reset", 48'(core_reset), 48'd0);
        req = 2'b00;
        wait_done(ok);
        check("clr_job_done_id", 48'(done_id), 48'd0);
        @(negedge clk);

        // Contention from reset: source 0 first, source 1 granted 2 cycles after done.
        do_reset();
        req = 2'b11;
        wait_gnt(ok);
        check("cont_first_gnt", 48'(gnt), 48'd1);
        wait_done(ok);
        check("cont_first_id", 48'(done_id), 48'd0);
        check("cont_first_cnt", res_cnt, CNT_EXP);
        n = 0;
        while (gnt == 2'b00 || n == 0) begin
            @(negedge clk);
            n++;
            if (n > 10) break;
        end
        check("cont_regrant_delay", 48'(n), 48'd2);
        check("cont_second_gnt", 48'(gnt), 48'd2);
        req = 2'b00;
        wait_done(ok);
        check("cont_second_id", 48'(done_id), 48'd1);
        check("cont_second_err", 48'(err_timeout), 48'd0);
        check("cont_second_cnt", res_cnt, CNT_EXP);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
